mips_divider: RTL and testbench

MIPS_DIVIDER -- requirements
Module: mips_divider

---
 rtl/mips_divider_if.sv | 25 ++
 rtl/mips_divider.sv | 129 ++++++++++++
 tb/tb_mips_divider.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_divider_if.sv
// Request/response bundle for mips_divider. The requester drives the operands
// and the start strobe; the divider returns status and results.
interface mips_divider_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             signdiv;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;
   logic             div0;

   modport master (
      output start, signdiv, a, b,
      input  busy, done, q, r, div0
   );

   modport slave (
      input  start, signdiv, a, b,
      output busy, done, q, r, div0
   );
endinterface

// File: rtl/mips_divider.sv
// Multi-cycle MIPS-style divider (DIV/DIVU/MOD/MODU). Restoring division on
// operand magnitudes, one quotient bit per cycle, followed by a sign-fix cycle.
// A zero divisor bypasses the datapath and reports div0 straight away.
module mips_divider #(
   parameter int WIDTH = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   mips_divider_if.slave bus
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_t;

   state_t           state_q;
   logic [WIDTH:0]   rem_q;      // partial remainder, one bit wider than the divisor
   logic [WIDTH-1:0] quo_q;      // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0] dvsr_q;     // divisor magnitude
   logic [CNT_W-1:0] cnt_q;      // quotient bits produced so far
   logic             neg_a_q;    // remainder takes the dividend's sign
   logic             neg_q_q;    // quotient negative when operand signs differ
   logic             busy_q;
   logic             done_q;
   logic             div0_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] r_q;

   logic [WIDTH:0]   shift_d;
   logic [WIDTH+1:0] diff_d;
   logic [WIDTH-1:0] mag_a_d;
   logic [WIDTH-1:0] mag_b_d;
   logic [WIDTH-1:0] q_fix_d;
   logic [WIDTH-1:0] r_fix_d;
   logic             accept_d;

   // Trial subtraction, operand magnitudes and sign-corrected results.
   // NOTE: every signal is assigned on every path through this block, so no latch is inferred.
   always_comb begin
      shift_d  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
      diff_d   = {1'b0, shift_d} - {2'b00, dvsr_q};
      mag_a_d  = (bus.signdiv && bus.a[WIDTH-1]) ? -bus.a : bus.a;
      mag_b_d  = (bus.signdiv && bus.b[WIDTH-1]) ? -bus.b : bus.b;
      q_fix_d  = neg_q_q ? -quo_q : quo_q;
      r_fix_d  = neg_a_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
      accept_d = bus.start && ((state_q == IDLE) || (state_q == DONE));
   end

   // Control FSM and datapath registers, including the registered outputs.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rem_q   <= '0;
         quo_q   <= '0;
         dvsr_q  <= '0;
         cnt_q   <= '0;
         neg_a_q <= 1'b0;
         neg_q_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         div0_q  <= 1'b0;
         q_q     <= '0;
         r_q     <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               if (accept_d) begin
                  div0_q  <= 1'b0;
                  quo_q   <= mag_a_d;
                  dvsr_q  <= mag_b_d;
                  rem_q   <= '0;
                  cnt_q   <= '0;
                  neg_a_q <= bus.signdiv & bus.a[WIDTH-1];
                  neg_q_q <= bus.signdiv & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  if (bus.b == '0) begin
                     // Zero divisor: report immediately with the raw dividend.
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     q_q     <= '1;
                     r_q     <= bus.a;
                     div0_q  <= 1'b1;
                  end else begin
                     state_q <= CALC;
                     busy_q  <= 1'b1;
                  end
               end
            end
            CALC: begin
               if (!diff_d[WIDTH+1]) begin
                  rem_q <= diff_d[WIDTH:0];
                  quo_q <= {quo_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_q <= shift_d;
                  quo_q <= {quo_q[WIDTH-2:0], 1'b0};
               end
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_q <= FIX;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            FIX: begin
               q_q     <= q_fix_d;
               r_q     <= r_fix_d;
               state_q <= DONE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.div0 = div0_q;
   assign bus.q    = q_q;
   assign bus.r    = r_q;

endmodule

// File: tb/tb_mips_divider.sv
// Directed bench for mips_divider (WIDTH=32): reset values, unsigned and
// signed results, overflow, zero divisor, ignored start, back-to-back and
// mid-operation reset. Latency L means done is seen in the cycle after E0+L-1.
module tb_mips_divider;

   logic clk;
   logic rst_n;

   mips_divider_if #(.WIDTH(32)) dif ();

   mips_divider #(.WIDTH(32)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (dif.slave)
   );

   int n_vec = 0;
   int n_err = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Present a request for one edge (E0); returns 1 ns after E0 with start low.
   task automatic apply(input logic [31:0] a_v, input logic [31:0] b_v, input logic sd);
      @(negedge clk);
      dif.start   = 1'b1;
      dif.a       = a_v;
      dif.b       = b_v;
      dif.signdiv = sd;
      @(posedge clk);
      #1;
      dif.start = 1'b0;
   endtask

   // Count cycles until done is seen, bounded; also counts busy cycles.
   task automatic wait_done(output int lat, output int nbusy);
      lat   = 1;
      nbusy = 0;
      while (dif.done !== 1'b1 && lat < 200) begin
         if (dif.busy === 1'b1) nbusy++;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   initial begin
      int lat;
      int lat2;
      int nbusy;
      int seen;

      dif.start   = 1'b0;
      dif.signdiv = 1'b0;
      dif.a       = '0;
      dif.b       = '0;
      rst_n       = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_busy", 32'(dif.busy), 32'd0);
      check("rst_done", 32'(dif.done), 32'd0);
      check("rst_div0", 32'(dif.div0), 32'd0);
      check("rst_q", dif.q, 32'd0);
      check("rst_r", dif.r, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // 100 / 7 unsigned
      apply(32'd100, 32'd7, 1'b0);
      wait_done(lat, nbusy);
      check("u100_7_lat", 32'(lat), 32'd34);
      check("u100_7_busycyc", 32'(nbusy), 32'd33);
      check("u100_7_q", dif.q, 32'd14);
      check("u100_7_r", dif.r, 32'd2);
      check("u100_7_div0", 32'(dif.div0), 32'd0);
      check("u100_7_busy_in_done", 32'(dif.busy), 32'd0);
      @(posedge clk);
      #1;
      check("done_one_cycle", 32'(dif.done), 32'd0);
      check("q_hold", dif.q, 32'd14);
      check("r_hold", dif.r, 32'd2);

      // -7 / 2 signed
      apply(32'hFFFF_FFF9, 32'd2, 1'b1);
      wait_done(lat, nbusy);
      check("sm7_2_lat", 32'(lat), 32'd34);
      check("sm7_2_q", dif.q, 32'hFFFF_FFFD);
      check("sm7_2_r", dif.r, 32'hFFFF_FFFF);

      // 7 / -2 signed
      apply(32'd7, 32'hFFFF_FFFE, 1'b1);
      wait_done(lat, nbusy);
      check("s7_m2_q", dif.q, 32'hFFFF_FFFD);
      check("s7_m2_r", dif.r, 32'd1);

      // -100 / -7 signed
      apply(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1);
      wait_done(lat, nbusy);
      check("sm100_m7_q", dif.q, 32'd14);
      check("sm100_m7_r", dif.r, 32'hFFFF_FFFE);

      // Overflow, signed then unsigned
      apply(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      wait_done(lat, nbusy);
      check("ovf_s_q", dif.q, 32'h8000_0000);
      check("ovf_s_r", dif.r, 32'd0);
      check("ovf_s_div0", 32'(dif.div0), 32'd0);
      apply(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      wait_done(lat, nbusy);
      check("ovf_u_q", dif.q, 32'd0);
      check("ovf_u_r", dif.r, 32'h8000_0000);

      // Zero divisor
      apply(32'h1234_5678, 32'd0, 1'b0);
      wait_done(lat, nbusy);
      check("z_lat", 32'(lat), 32'd1);
      check("z_busy", 32'(dif.busy), 32'd0);
      check("z_q", dif.q, 32'hFFFF_FFFF);
      check("z_r", dif.r, 32'h1234_5678);
      check("z_div0", 32'(dif.div0), 32'd1);
      @(posedge clk);
      #1;
      check("z_done_drop", 32'(dif.done), 32'd0);
      check("z_div0_hold", 32'(dif.div0), 32'd1);

      // Start pulsed at E0+5 with different operands is ignored
      apply(32'd100, 32'd7, 1'b0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      dif.start = 1'b1;
      dif.a     = 32'd5;
      dif.b     = 32'd1;
      @(posedge clk);
      #1;
      dif.start = 1'b0;
      wait_done(lat, nbusy);
      check("ign_lat", 32'(lat + 5), 32'd34);
      check("ign_q", dif.q, 32'd14);
      check("ign_r", dif.r, 32'd2);
      check("ign_div0_cleared", 32'(dif.div0), 32'd0);

      // Start held high through DONE: second request accepted without a gap
      @(negedge clk);
      dif.start   = 1'b1;
      dif.a       = 32'd1000;
      dif.b       = 32'd3;
      dif.signdiv = 1'b0;
      @(posedge clk);
      #1;
      wait_done(lat, nbusy);
      check("b2b_lat1", 32'(lat), 32'd34);
      check("b2b_q1", dif.q, 32'd333);
      check("b2b_r1", dif.r, 32'd1);
      dif.a       = 32'hFFFF_FF9C;
      dif.b       = 32'hFFFF_FFF9;
      dif.signdiv = 1'b1;
      @(posedge clk);
      #1;
      dif.start = 1'b0;
      check("b2b_busy2", 32'(dif.busy), 32'd1);
      wait_done(lat2, nbusy);
      check("b2b_lat2", 32'(34 + lat2), 32'd68);
      check("b2b_q2", dif.q, 32'd14);
      check("b2b_r2", dif.r, 32'hFFFF_FFFE);

      // Reset mid-CALC aborts; outputs clear without a clock edge
      apply(32'hFFFF_FFFF, 32'h10, 1'b0);
      repeat (10) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(dif.busy), 32'd0);
      check("mid_rst_done", 32'(dif.done), 32'd0);
      check("mid_rst_q", dif.q, 32'd0);
      check("mid_rst_r", dif.r, 32'd0);
      check("mid_rst_div0", 32'(dif.div0), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (dif.done === 1'b1 || dif.busy === 1'b1) seen++;
      end
      check("mid_rst_no_done", 32'(seen), 32'd0);
      apply(32'hFFFF_FFFF, 32'h10, 1'b0);
      wait_done(lat, nbusy);
      check("post_rst_lat", 32'(lat), 32'd34);
      check("post_rst_q", dif.q, 32'h0FFF_FFFF);
      check("post_rst_r", dif.r, 32'h0000_000F);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
